// File: rtl/gate_tester.sv
// ============================================================================
//  Module   : gate_tester
//  Purpose  : Exhaustive truth-table sweep of a 2-input gate. Each {A,B}
//             vector is held for SETTLE_CYCLES, sampled for one cycle and
//             compared against EXPECT_TT. Optional macro GATE_TESTER_LOOP_EN
//             enables continuous sweeping plus a saturating error counter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module gate_tester #(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] EXPECT_TT     = 4'b1110
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dut_out,
    output logic       A,
    output logic       B,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_vec
`ifdef GATE_TESTER_LOOP_EN
    ,
    output logic [7:0] err_count
`endif
);

    // Zero is promoted to one; anything beyond the 4-bit counter is clamped.
    localparam logic [3:0] c_SETTLE_LOAD = (SETTLE_CYCLES < 1)  ? 4'd1  :
                                           (SETTLE_CYCLES > 15) ? 4'd15 :
                                           4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic       w_launch;
    logic [1:0] r_idx;
    logic [1:0] r_ab;
    logic [3:0] r_cnt;
    logic [3:0] r_fail_vec;
    logic       r_pass;
    logic       w_mismatch;
    logic [3:0] w_fail_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_launch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_launch     = 1'b1;
                    w_next_state = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_cnt <= 4'd1) begin
                    w_next_state = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                w_next_state = (r_idx == 2'd3) ? S_DONE : S_SETTLE;
            end
            S_DONE: begin
`ifdef GATE_TESTER_LOOP_EN
                w_launch     = 1'b1;
                w_next_state = S_SETTLE;
`else
                w_next_state = S_IDLE;
`endif
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // The final vector's mismatch is folded in before pass is evaluated.
    assign w_mismatch  = (r_state == S_SAMPLE) && (dut_out != EXPECT_TT[r_idx]);
    assign w_fail_next = r_fail_vec | ({3'b000, w_mismatch} << r_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= 2'd0;
            r_ab       <= 2'b00;
            r_cnt      <= 4'd0;
            r_fail_vec <= 4'b0000;
            r_pass     <= 1'b0;
        end else if (w_launch) begin
            r_idx      <= 2'd0;
            r_ab       <= 2'b00;
            r_cnt      <= c_SETTLE_LOAD;
            r_fail_vec <= 4'b0000;
            r_pass     <= 1'b0;
        end else begin
            case (r_state)
                S_SETTLE: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_SAMPLE: begin
                    r_fail_vec <= w_fail_next;
                    if (r_idx == 2'd3) begin
                        r_ab   <= 2'b00;
                        r_cnt  <= 4'd0;
                        r_pass <= (w_fail_next == 4'b0000);
                    end else begin
                        r_idx <= r_idx + 2'd1;
                        r_ab  <= r_idx + 2'd1;
                        r_cnt <= c_SETTLE_LOAD;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef GATE_TESTER_LOOP_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= 8'd0;
        end else if ((r_state == S_DONE) && (r_fail_vec != 4'b0000) &&
                     (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

    assign A        = r_ab[1];
    assign B        = r_ab[0];
    assign busy     = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
    assign done     = (r_state == S_DONE);
    assign pass     = r_pass;
    assign fail_vec = r_fail_vec;

endmodule

`default_nettype wire

// File: tb/tb_gate_tester.sv
// ============================================================================
//  Module   : tb_gate_tester
//  Purpose  : Self-checking bench for gate_tester; dut_out is driven from a
//             bench-side truth table. Define GATE_TESTER_LOOP_EN for the
//             continuous-sweep build.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_gate_tester;

    localparam int         S       = 2;
    localparam logic [3:0] EXP_TT  = 4'b1110;
    localparam int         VEC_CYC = S + 1;
    localparam int         SWEEP   = 4 * VEC_CYC;
    localparam int         WIN     = SWEEP + 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] tt    = 4'b0000;
    logic       dut_out;
    logic       A, B, busy, done, pass;
    logic [3:0] fail_vec;
`ifdef GATE_TESTER_LOOP_EN
    logic [7:0] err_count;
`endif

    int errors = 0;
    int checks = 0;

    logic [1:0] cap_ab   [WIN];
    logic       cap_busy [WIN];
    logic       cap_done [WIN];
    logic [3:0] cap_fail;
    logic       cap_pass;
    logic [3:0] cap_fail0;
    logic       cap_pass0;
    int         cap_dones;

    gate_tester #(
        .SETTLE_CYCLES (S),
        .EXPECT_TT     (EXP_TT)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dut_out  (dut_out),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .fail_vec (fail_vec)
`ifdef GATE_TESTER_LOOP_EN
        ,
        .err_count(err_count)
`endif
    );

    assign dut_out = tt[{A, B}];

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Index k of the capture arrays is the cycle after the k-th edge,
    // counting the edge that samples start as edge 0.
    task automatic capture_sweep(input int restart_at);
        start = 1'b1;
        step();
        start     = 1'b0;
        cap_dones = 0;
        cap_fail0 = fail_vec;
        cap_pass0 = pass;
        for (int k = 0; k < WIN; k++) begin
            cap_ab[k]   = {A, B};
            cap_busy[k] = busy;
            cap_done[k] = done;
            if (done) cap_dones++;
            if (k == SWEEP) begin
                cap_fail = fail_vec;
                cap_pass = pass;
            end
            start = (k == restart_at);
            step();
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({A, B, busy, done, pass, fail_vec} !== 9'b0) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", {A, B, busy, done, pass, fail_vec}, 9'b0);
        end
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_or_sweep();
        logic [3:0] exp_ab_busy_done;
        tt = 4'b1110;
        capture_sweep(-1);
        for (int k = 0; k < WIN; k++) begin
            if (k < SWEEP) exp_ab_busy_done = {2'(k / VEC_CYC), 1'b1, 1'b0};
            else if (k == SWEEP) exp_ab_busy_done = 4'b0001;
            else exp_ab_busy_done = 4'b0000;
            checks++;
            if ({cap_ab[k], cap_busy[k], cap_done[k]} !== exp_ab_busy_done) begin
                errors++;
                $display("FAIL or_timeline[%0d]: {A,B,busy,done} got %b expected %b", k,
                         {cap_ab[k], cap_busy[k], cap_done[k]}, exp_ab_busy_done);
            end
        end
        checks++;
        if ({cap_pass, cap_fail} !== 5'b1_0000) begin
            errors++;
            $display("FAIL or_result: {pass,fail_vec} got %b expected 10000", {cap_pass, cap_fail});
        end
        tt = 4'b0000;
        repeat (4) step();
        checks++;
        if ({pass, fail_vec} !== 5'b1_0000) begin
            errors++;
            $display("FAIL or_hold: {pass,fail_vec} got %b expected 10000", {pass, fail_vec});
        end
    endtask

    task automatic test_tied_zero();
        tt = 4'b0000;
        capture_sweep(-1);
        checks++;
        if ({cap_pass0, cap_fail0} !== 5'b0_0000) begin
            errors++;
            $display("FAIL start_clears: {pass,fail_vec} got %b expected 00000", {cap_pass0, cap_fail0});
        end
        checks++;
        if ({cap_pass, cap_fail} !== 5'b0_1110) begin
            errors++;
            $display("FAIL tied0_result: {pass,fail_vec} got %b expected 01110", {cap_pass, cap_fail});
        end
    endtask

    task automatic test_and_gate();
        tt = 4'b1000;
        capture_sweep(-1);
        checks++;
        if ({cap_pass, cap_fail} !== 5'b0_0110) begin
            errors++;
            $display("FAIL and_result: {pass,fail_vec} got %b expected 00110", {cap_pass, cap_fail});
        end
        checks++;
        if (cap_done[SWEEP] !== 1'b1 || cap_dones != 1) begin
            errors++;
            $display("FAIL and_done: done@%0d got %b, pulses got %0d expected 1", SWEEP, cap_done[SWEEP], cap_dones);
        end
    endtask

    task automatic test_restart_ignored();
        tt = 4'b1110;
        capture_sweep(5);
        checks++;
        if (cap_dones != 1 || cap_done[SWEEP] !== 1'b1) begin
            errors++;
            $display("FAIL restart_done: pulses got %0d expected 1, done@%0d got %b", cap_dones, SWEEP, cap_done[SWEEP]);
        end
        for (int k = 6; k < SWEEP; k++) begin
            checks++;
            if (cap_ab[k] !== 2'(k / VEC_CYC)) begin
                errors++;
                $display("FAIL restart_ab[%0d]: got %b expected %b", k, cap_ab[k], 2'(k / VEC_CYC));
            end
        end
        checks++;
        if (cap_pass !== 1'b1) begin
            errors++;
            $display("FAIL restart_pass: got %b expected 1", cap_pass);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        tt = 4'b1110;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        checks++;
        if ({A, B, busy} !== 3'b101) begin
            errors++;
            $display("FAIL mid_pre_reset: {A,B,busy} got %b expected 101", {A, B, busy});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({A, B, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset_async: {A,B,busy,done} got %b expected 0000", {A, B, busy, done});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < SWEEP + 4; k++) begin
            step();
            if (done || busy) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL mid_abort: done/busy cycles got %0d expected 0", dones);
        end
        capture_sweep(-1);
        checks++;
        if (cap_dones != 1 || cap_done[SWEEP] !== 1'b1 || cap_pass !== 1'b1) begin
            errors++;
            $display("FAIL mid_fresh_sweep: pulses %0d done@%0d %b pass %b, expected 1 1 1",
                     cap_dones, SWEEP, cap_done[SWEEP], cap_pass);
        end
    endtask

    // Start held high: second sweep begins at the first IDLE edge after DONE.
    task automatic test_back_to_back();
        int first_done, second_done, ndone;
        tt = 4'b1110;
        first_done = -1;
        second_done = -1;
        ndone = 0;
        start = 1'b1;
        step();
        for (int k = 0; k <= 2 * SWEEP + 2; k++) begin
            if (done) begin
                ndone++;
                if (ndone == 1) first_done = k;
                else if (ndone == 2) second_done = k;
            end
            step();
        end
        start = 1'b0;
        repeat (2) step();
        checks++;
        if (first_done != SWEEP || second_done != 2 * SWEEP + 2 || ndone != 2) begin
            errors++;
            $display("FAIL back_to_back: done at %0d,%0d (n=%0d) expected %0d,%0d (n=2)",
                     first_done, second_done, ndone, SWEEP, 2 * SWEEP + 2);
        end
    endtask

    task automatic test_random();
        logic [3:0] exp_fail;
        int         restart_at;
        for (int it = 0; it < 24; it++) begin
            tt = 4'($urandom);
            restart_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, SWEEP - 1)) : -1;
            repeat ($urandom_range(0, 3)) step();
            capture_sweep(restart_at);
            for (int v = 0; v < 4; v++) exp_fail[v] = (tt[v] != EXP_TT[v]);
            checks++;
            if ({cap_pass, cap_fail} !== {(exp_fail == 4'b0000), exp_fail}) begin
                errors++;
                $display("FAIL random[%0d] tt=%b: {pass,fail_vec} got %b expected %b", it, tt,
                         {cap_pass, cap_fail}, {(exp_fail == 4'b0000), exp_fail});
            end
            checks++;
            if (cap_dones != 1 || cap_done[SWEEP] !== 1'b1) begin
                errors++;
                $display("FAIL random_done[%0d]: pulses %0d done@%0d %b, expected 1 and 1",
                         it, cap_dones, SWEEP, cap_done[SWEEP]);
            end
        end
    endtask

`ifdef GATE_TESTER_LOOP_EN
    // The DONE cycle itself precedes each restarted sweep, so the spacing
    // between pulses is one sweep plus that cycle.
    task automatic test_loop();
        int n, last, gap_bad, cnt_bad;
        logic prev_done;
        tt = 4'b1111;
        n = 0;
        last = 0;
        gap_bad = 0;
        cnt_bad = 0;
        prev_done = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < SWEEP + 260 * (SWEEP + 1); k++) begin
            if (prev_done) begin
                checks++;
                if (err_count !== 8'((n > 255) ? 255 : n)) begin
                    errors++;
                    $display("FAIL loop_err_count after sweep %0d: got %0d expected %0d",
                             n, err_count, (n > 255) ? 255 : n);
                end
            end
            if (done) begin
                n++;
                if (k - last != ((n == 1) ? SWEEP : SWEEP + 1)) gap_bad++;
                last = k;
            end
            prev_done = done;
            step();
        end
        checks++;
        if (gap_bad != 0 || n < 258) begin
            errors++;
            $display("FAIL loop_period: bad gaps %0d, sweeps %0d expected 0 and >=258", gap_bad, n);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef GATE_TESTER_LOOP_EN
        test_loop();
`else
        test_or_sweep();
        test_tied_zero();
        test_and_gate();
        test_restart_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
